// File: rtl/control_pipe_pkg.sv
// Shared decode constants and control-word layout for the pipelined MIPS controller.
// Holds opcode/func encodings, ALU op codes, shift-select codes and stage structs.
// Imported by ctrl_decode and control_pipe.
package control_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_ADDU = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_SUBU = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_SLT  = 4'd11
  } alu_op_e;

  // instruction[31:26]
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_BGEZ   = 6'h01;  // REGIMM group, only bgez is decoded
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // instruction[5:0] for R-type
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ex_shift: 01 = shift by shamt, 10 = lui (imm << 16)
  localparam logic [1:0] SHIFT_NONE  = 2'b00;
  localparam logic [1:0] SHIFT_SHAMT = 2'b01;
  localparam logic [1:0] SHIFT_LUI   = 2'b10;

  // Control word carried down the pipe; all-zero is a bubble.
  typedef struct packed {
    logic       valid;
    alu_op_e    aluop;
    logic       alusrc;
    logic [1:0] shift;
    logic       signext;
    logic       branch;
    logic       jump;
    logic       read;
    logic       write;
    logic       regwrite;
    logic       memtoreg;
  } stage_ctrl_t;

  // Decoder output: the control word plus ID-only fields that never leave ID.
  typedef struct packed {
    stage_ctrl_t cw;
    logic        regdst;
    logic        reads_rt;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode/func decode into a control word (no state).
// Ports: i_opcode, i_func in; o_dec out (control word, regdst, reads_rt).
// Unknown opcode yields all-zero (bubble); unknown R-type func yields ALU_NOP, no writeback.
module ctrl_decode
  import control_pipe_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_func,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    o_dec.cw.valid = 1'b1;
    case (i_opcode)
      OP_RTYPE: begin
        o_dec.regdst      = 1'b1;
        o_dec.reads_rt    = 1'b1;
        o_dec.cw.regwrite = 1'b1;
        case (i_func)
          FN_ADD:  o_dec.cw.aluop = ALU_ADD;
          FN_ADDU: o_dec.cw.aluop = ALU_ADDU;
          FN_SUB:  o_dec.cw.aluop = ALU_SUB;
          FN_SUBU: o_dec.cw.aluop = ALU_SUBU;
          FN_AND:  o_dec.cw.aluop = ALU_AND;
          FN_OR:   o_dec.cw.aluop = ALU_OR;
          FN_NOR:  o_dec.cw.aluop = ALU_NOR;
          FN_SLT:  o_dec.cw.aluop = ALU_SLT;
          FN_SLL: begin
            o_dec.cw.aluop = ALU_SLL;
            o_dec.cw.shift = SHIFT_SHAMT;
          end
          FN_SRL: begin
            o_dec.cw.aluop = ALU_SRL;
            o_dec.cw.shift = SHIFT_SHAMT;
          end
          FN_SRA: begin
            o_dec.cw.aluop = ALU_SRA;
            o_dec.cw.shift = SHIFT_SHAMT;
          end
          FN_JR: begin
            o_dec.cw.jump     = 1'b1;
            o_dec.cw.regwrite = 1'b0;
          end
          default: o_dec.cw.regwrite = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI: begin
        o_dec.cw.alusrc   = 1'b1;
        o_dec.cw.regwrite = 1'b1;
        o_dec.cw.signext  = 1'b1;
        case (i_opcode)
          OP_ADDI:  o_dec.cw.aluop = ALU_ADD;
          OP_ADDIU: o_dec.cw.aluop = ALU_ADDU;
          OP_ANDI:  o_dec.cw.aluop = ALU_AND;
          default:  o_dec.cw.aluop = ALU_SLT;
        endcase
      end
      OP_ORI: begin
        o_dec.cw.aluop    = ALU_OR;
        o_dec.cw.alusrc   = 1'b1;
        o_dec.cw.regwrite = 1'b1;
      end
      OP_LUI: begin
        o_dec.cw.aluop    = ALU_SLL;
        o_dec.cw.shift    = SHIFT_LUI;
        o_dec.cw.alusrc   = 1'b1;
        o_dec.cw.regwrite = 1'b1;
      end
      OP_LW: begin
        o_dec.cw.aluop    = ALU_ADD;
        o_dec.cw.alusrc   = 1'b1;
        o_dec.cw.signext  = 1'b1;
        o_dec.cw.read     = 1'b1;
        o_dec.cw.regwrite = 1'b1;
        o_dec.cw.memtoreg = 1'b1;
      end
      OP_SW: begin
        o_dec.reads_rt   = 1'b1;
        o_dec.cw.aluop   = ALU_ADD;
        o_dec.cw.alusrc  = 1'b1;
        o_dec.cw.signext = 1'b1;
        o_dec.cw.write   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        o_dec.reads_rt   = 1'b1;
        o_dec.cw.aluop   = ALU_SUB;
        o_dec.cw.branch  = 1'b1;
        o_dec.cw.signext = 1'b1;
      end
      OP_BGTZ, OP_BGEZ: begin
        o_dec.cw.aluop   = ALU_SUB;
        o_dec.cw.branch  = 1'b1;
        o_dec.cw.signext = 1'b1;
      end
      default: o_dec = '0;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined MIPS control: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, taken-branch flush and multi-cycle memory wait.
// Ports: ID instruction fields + ex_redirect in; id_stall, EX/MEM/WB control out.
module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int ALUOP_W  = 4,
  parameter int RADDR_W  = 5,
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
)(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_id_valid,
  input  logic [5:0]         i_id_opcode,
  input  logic [5:0]         i_id_func,
  input  logic [RADDR_W-1:0] i_id_rs,
  input  logic [RADDR_W-1:0] i_id_rt,
  input  logic [RADDR_W-1:0] i_id_rd,
  input  logic               i_ex_redirect,
  output logic               o_id_stall,
  output logic               o_ex_valid,
  output logic [ALUOP_W-1:0] o_ex_aluop,
  output logic               o_ex_alusrc,
  output logic [1:0]         o_ex_shift,
  output logic               o_ex_signext,
  output logic               o_ex_branch,
  output logic               o_ex_jump,
  output logic [RADDR_W-1:0] o_ex_waddr,
  output logic               o_mem_valid,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_busy,
  output logic               o_wb_valid,
  output logic               o_wb_regwrite,
  output logic               o_wb_memtoreg,
  output logic [RADDR_W-1:0] o_wb_waddr
);

  localparam logic WAIT_EN = (MEM_WAIT > 0);

  dec_t               w_dec;
  stage_ctrl_t        w_id_cw;
  logic [RADDR_W-1:0] w_id_waddr;
  logic               w_load_use;
  logic               w_mem_busy;
  logic               w_start_wait;

  stage_ctrl_t        r_ex_cw;
  logic [RADDR_W-1:0] r_ex_waddr;
  logic               r_mem_valid, r_mem_read, r_mem_write, r_mem_regwrite, r_mem_memtoreg;
  logic [RADDR_W-1:0] r_mem_waddr;
  logic               r_wb_valid, r_wb_regwrite, r_wb_memtoreg;
  logic [RADDR_W-1:0] r_wb_waddr;
  logic [CNT_W-1:0]   r_cnt;

  ctrl_decode u_decode (
    .i_opcode (i_id_opcode),
    .i_func   (i_id_func),
    .o_dec    (w_dec)
  );

  // ID control word; an invalid slot or an unknown opcode is a full bubble,
  // and writes to r0 are suppressed here so no later stage needs to care.
  always_comb begin
    w_id_cw    = '0;
    w_id_waddr = '0;
    if (i_id_valid && w_dec.cw.valid) begin
      w_id_cw    = w_dec.cw;
      w_id_waddr = w_dec.regdst ? i_id_rd : i_id_rt;
      if (w_id_waddr == '0) begin
        w_id_cw.regwrite = 1'b0;
      end
    end
  end

  assign w_load_use = w_id_cw.valid && r_ex_cw.valid && r_ex_cw.read &&
                      (r_ex_waddr != '0) &&
                      ((r_ex_waddr == i_id_rs) ||
                       (w_dec.reads_rt && (r_ex_waddr == i_id_rt)));

  assign w_mem_busy   = (r_cnt != '0);
  // A load/store entering MEM arms the wait counter on the same edge.
  assign w_start_wait = WAIT_EN && r_ex_cw.valid && (r_ex_cw.read || r_ex_cw.write);

  // A redirect cancels the ID instruction, so there is nothing left to stall.
  assign o_id_stall = w_mem_busy || (w_load_use && !i_ex_redirect);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_cw        <= '0;
      r_ex_waddr     <= '0;
      r_mem_valid    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_waddr    <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_waddr     <= '0;
      r_cnt          <= '0;
    end else if (w_mem_busy) begin
      // EX and MEM hold; WB sees a bubble while memory is still working.
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
      r_wb_memtoreg <= 1'b0;
      r_wb_waddr    <= '0;
      r_cnt         <= r_cnt - 1'b1;
    end else begin
      r_wb_valid     <= r_mem_valid;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_waddr     <= r_mem_waddr;
      r_mem_valid    <= r_ex_cw.valid;
      r_mem_read     <= r_ex_cw.read;
      r_mem_write    <= r_ex_cw.write;
      r_mem_regwrite <= r_ex_cw.regwrite;
      r_mem_memtoreg <= r_ex_cw.memtoreg;
      r_mem_waddr    <= r_ex_waddr;
      r_cnt          <= w_start_wait ? CNT_W'(MEM_WAIT) : '0;
      if (i_ex_redirect || w_load_use) begin
        r_ex_cw    <= '0;
        r_ex_waddr <= '0;
      end else begin
        r_ex_cw    <= w_id_cw;
        r_ex_waddr <= w_id_waddr;
      end
    end
  end

  assign o_ex_valid    = r_ex_cw.valid;
  assign o_ex_aluop    = ALUOP_W'(r_ex_cw.aluop);
  assign o_ex_alusrc   = r_ex_cw.alusrc;
  assign o_ex_shift    = r_ex_cw.shift;
  assign o_ex_signext  = r_ex_cw.signext;
  assign o_ex_branch   = r_ex_cw.branch;
  assign o_ex_jump     = r_ex_cw.jump;
  assign o_ex_waddr    = r_ex_waddr;
  assign o_mem_valid   = r_mem_valid;
  assign o_mem_read    = r_mem_read;
  assign o_mem_write   = r_mem_write;
  assign o_mem_busy    = w_mem_busy;
  assign o_wb_valid    = r_wb_valid;
  assign o_wb_regwrite = r_wb_regwrite;
  assign o_wb_memtoreg = r_wb_memtoreg;
  assign o_wb_waddr    = r_wb_waddr;

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe with MEM_WAIT=3: directed scenarios then random
// instruction streams, checked against a stage-list reference model.
// Expected outputs are queued per cycle; a negedge monitor pops and compares.
module tb_control_pipe;
  import control_pipe_pkg::*;

  localparam int MW = 3;

  logic       clk = 1'b0;
  logic       rst, id_valid, ex_redirect;
  logic [5:0] id_opcode, id_func;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_stall, ex_valid, ex_alusrc, ex_signext, ex_branch, ex_jump;
  logic [3:0] ex_aluop;
  logic [1:0] ex_shift;
  logic [4:0] ex_waddr, wb_waddr;
  logic       mem_valid, mem_read, mem_write, mem_busy;
  logic       wb_valid, wb_regwrite, wb_memtoreg;

  always #5 clk = ~clk;

  control_pipe #(.ALUOP_W(4), .RADDR_W(5), .MEM_WAIT(MW), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_opcode(id_opcode),
    .i_id_func(id_func), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd),
    .i_ex_redirect(ex_redirect), .o_id_stall(id_stall), .o_ex_valid(ex_valid),
    .o_ex_aluop(ex_aluop), .o_ex_alusrc(ex_alusrc), .o_ex_shift(ex_shift),
    .o_ex_signext(ex_signext), .o_ex_branch(ex_branch), .o_ex_jump(ex_jump),
    .o_ex_waddr(ex_waddr), .o_mem_valid(mem_valid), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_mem_busy(mem_busy), .o_wb_valid(wb_valid),
    .o_wb_regwrite(wb_regwrite), .o_wb_memtoreg(wb_memtoreg), .o_wb_waddr(wb_waddr)
  );

  // One in-flight instruction as the reference sees it.
  typedef struct {
    bit valid; int aluop; bit alusrc; int shift; bit signext; bit branch; bit jump;
    bit read; bit write; bit regwrite; bit memtoreg; int waddr;
  } instr_t;

  typedef struct {
    int stall; instr_t ex; instr_t mem; int busy; instr_t wb;
  } exp_t;

  instr_t m_ex, m_mem, m_wb;
  int     m_wait = 0;
  bit     armed = 0;
  exp_t   q[$];
  int     n_checks = 0, n_pass = 0;
  int     c_stall = 0, c_busy = 0, c_mwrite = 0, c_wbv = 0, c_wbrw = 0;

  function automatic instr_t bubble();
    instr_t b = '{default: 0};
    return b;
  endfunction

  // Instruction-set table: what each instruction asks of the datapath.
  function automatic instr_t ref_decode(bit v, int op, int fn, int rt, int rd);
    instr_t d = '{default: 0};
    bit to_rd = 0;
    if (!v) return d;
    d.valid = 1;
    case (op)
      'h00: begin
        to_rd = 1; d.regwrite = 1;
        case (fn)
          'h20: d.aluop = ALU_ADD;   'h21: d.aluop = ALU_ADDU;
          'h22: d.aluop = ALU_SUB;   'h23: d.aluop = ALU_SUBU;
          'h24: d.aluop = ALU_AND;   'h25: d.aluop = ALU_OR;
          'h27: d.aluop = ALU_NOR;   'h2A: d.aluop = ALU_SLT;
          'h00: begin d.aluop = ALU_SLL; d.shift = 1; end
          'h02: begin d.aluop = ALU_SRL; d.shift = 1; end
          'h03: begin d.aluop = ALU_SRA; d.shift = 1; end
          'h08: begin d.jump = 1; d.regwrite = 0; end
          default: d.regwrite = 0;
        endcase
      end
      'h08, 'h09, 'h0A, 'h0C: begin
        d.alusrc = 1; d.regwrite = 1; d.signext = 1;
        d.aluop = (op == 'h08) ? ALU_ADD : (op == 'h09) ? ALU_ADDU :
                  (op == 'h0C) ? ALU_AND : ALU_SLT;
      end
      'h0D: begin d.aluop = ALU_OR; d.alusrc = 1; d.regwrite = 1; end
      'h0F: begin d.aluop = ALU_SLL; d.shift = 2; d.alusrc = 1; d.regwrite = 1; end
      'h23: begin
        d.aluop = ALU_ADD; d.alusrc = 1; d.signext = 1;
        d.read = 1; d.regwrite = 1; d.memtoreg = 1;
      end
      'h2B: begin d.aluop = ALU_ADD; d.alusrc = 1; d.signext = 1; d.write = 1; end
      'h04, 'h05, 'h07, 'h01: begin d.aluop = ALU_SUB; d.branch = 1; d.signext = 1; end
      default: return bubble();
    endcase
    d.waddr = to_rd ? rd : rt;
    if (d.waddr == 0) d.regwrite = 0;
    return d;
  endfunction

  function automatic bit uses_rt(int op);
    return (op == 'h00) || (op == 'h04) || (op == 'h05) || (op == 'h2B);
  endfunction

  task automatic chk(string nm, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, advance the model.
  task automatic tick(input bit r, input bit v, input int op, input int fn,
                      input int rs, input int rt, input int rd, input bit redir,
                      output bit stall);
    instr_t idd;
    bit     hz;
    exp_t   e;
    rst = r; id_valid = v; id_opcode = 6'(op); id_func = 6'(fn);
    id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd); ex_redirect = redir;
    idd = ref_decode(v, op, fn, rt, rd);
    hz = idd.valid && m_ex.valid && m_ex.read && (m_ex.waddr != 0) &&
         ((m_ex.waddr == rs) || (uses_rt(op) && (m_ex.waddr == rt)));
    stall = (m_wait > 0) || (hz && !redir);
    if (armed) begin
      e.stall = int'(stall); e.ex = m_ex; e.mem = m_mem; e.busy = int'(m_wait > 0); e.wb = m_wb;
      q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); m_wait = 0; armed = 1;
    end else if (m_wait > 0) begin
      m_wb = bubble(); m_wait--;
    end else begin
      m_wb = m_mem; m_mem = m_ex;
      m_wait = (m_mem.valid && (m_mem.read || m_mem.write)) ? MW : 0;
      m_ex = (redir || hz) ? bubble() : idd;
    end
    #1;
  endtask

  // Fetch behaviour: present the same instruction until ID accepts it.
  task automatic issue(input bit v, input int op, input int fn, input int rs,
                       input int rt, input int rd, input bit redir);
    bit st;
    int g = 0;
    do begin
      tick(0, v, op, fn, rs, rt, rd, redir, st);
      g++;
    end while (st && g < 32);
    if (st) chk("issue_stall_bound", 1, 0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clr_counts();
    c_stall = 0; c_busy = 0; c_mwrite = 0; c_wbv = 0; c_wbrw = 0;
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      c_stall += int'(id_stall); c_busy += int'(mem_busy); c_mwrite += int'(mem_write);
      c_wbv += int'(wb_valid); c_wbrw += int'(wb_regwrite);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_stall", int'(id_stall), e.stall);
        chk("ex_valid", int'(ex_valid), int'(e.ex.valid));
        chk("ex_aluop", int'(ex_aluop), e.ex.aluop);
        chk("ex_alusrc", int'(ex_alusrc), int'(e.ex.alusrc));
        chk("ex_shift", int'(ex_shift), e.ex.shift);
        chk("ex_signext", int'(ex_signext), int'(e.ex.signext));
        chk("ex_branch", int'(ex_branch), int'(e.ex.branch));
        chk("ex_jump", int'(ex_jump), int'(e.ex.jump));
        chk("ex_waddr", int'(ex_waddr), e.ex.waddr);
        chk("mem_valid", int'(mem_valid), int'(e.mem.valid));
        chk("mem_read", int'(mem_read), int'(e.mem.read));
        chk("mem_write", int'(mem_write), int'(e.mem.write));
        chk("mem_busy", int'(mem_busy), e.busy);
        chk("wb_valid", int'(wb_valid), int'(e.wb.valid));
        chk("wb_regwrite", int'(wb_regwrite), int'(e.wb.regwrite));
        chk("wb_memtoreg", int'(wb_memtoreg), int'(e.wb.memtoreg));
        chk("wb_waddr", int'(wb_waddr), e.wb.waddr);
      end
    end
  end

  int ops[16] = '{'h00, 'h00, 'h00, 'h08, 'h09, 'h0A, 'h0C, 'h0D,
                  'h0F, 'h23, 'h23, 'h2B, 'h04, 'h05, 'h07, 'h3F};
  int fns[13] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h27, 'h00,
                  'h02, 'h03, 'h2A, 'h08, 'h3E};

  initial begin
    bit st;
    rst = 1; id_valid = 0; id_opcode = 0; id_func = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; ex_redirect = 0;
    // reset for two cycles; the second cycle checks the reset state
    tick(1, 0, 0, 0, 0, 0, 0, 0, st);
    tick(1, 0, 0, 0, 0, 0, 0, 0, st);

    // addi rt=5
    issue(1, 'h08, 0, 1, 5, 0, 0);
    nops(5);

    // lw rt=8 then add rs=8: load-use stall plus the lw memory wait
    clr_counts();
    issue(1, 'h23, 0, 1, 8, 0, 0);
    issue(1, 'h00, 'h20, 8, 2, 9, 0);
    nops(10);
    chk("t2_stall_cycles", c_stall, 1 + MW);

    // sw with a 3-cycle wait
    clr_counts();
    issue(1, 'h2B, 0, 1, 3, 0, 0);
    nops(10);
    chk("t3_busy_cycles", c_busy, MW);
    chk("t3_memwrite_cycles", c_mwrite, MW + 1);
    chk("t3_wb_valid_cycles", c_wbv, 1);

    // beq followed by ori flushed by redirect
    clr_counts();
    issue(1, 'h04, 0, 1, 2, 0, 0);
    issue(1, 'h0D, 0, 1, 6, 0, 1);
    nops(8);
    chk("t4_wb_valid_cycles", c_wbv, 1);

    // lw rt=0 then add rs=0: no load-use stall, lw never writes back
    clr_counts();
    issue(1, 'h23, 0, 1, 0, 0, 0);
    issue(1, 'h00, 'h20, 0, 2, 7, 0);
    nops(10);
    chk("t5_stall_cycles", c_stall, MW);
    chk("t5_wb_regwrite_cycles", c_wbrw, 1);

    // reset while the counter reads 2
    issue(1, 'h2B, 0, 1, 3, 0, 0);
    for (int g = 0; g < 10 && m_wait != 2; g++) tick(0, 0, 0, 0, 0, 0, 0, 0, st);
    chk("t6_reached_wait2", m_wait, 2);
    tick(1, 0, 0, 0, 0, 0, 0, 0, st);
    issue(1, 'h08, 0, 2, 4, 0, 0);
    nops(6);

    // random instruction stream with small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        tick(1, 0, 0, 0, 0, 0, 0, 0, st);
      end else begin
        issue($urandom_range(0, 9) != 0, ops[$urandom_range(0, 15)],
              fns[$urandom_range(0, 12)], $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 9) == 0);
      end
    end
    nops(8);

    @(negedge clk);
    #1;
    chk("scoreboard_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
